// File: rtl/clock_pkg.sv
// Shared range constants and step direction type for the time-unit counter chain.
package clock_pkg;

  localparam int unsigned SEC_MAX   = 59;
  localparam int unsigned MIN_MAX   = 59;
  localparam int unsigned HOUR_MAX  = 23;
  localparam int unsigned DAY_MIN   = 1;
  localparam int unsigned DAY_MAX   = 31;
  localparam int unsigned MONTH_MIN = 1;
  localparam int unsigned MONTH_MAX = 12;
  localparam int unsigned YEAR_MAX  = 99;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } step_dir_e;

endpackage

// File: rtl/unit_step.sv
// Combinational modulo step: next value and wrap flag for one up/down step.
module unit_step
  import clock_pkg::*;
#(
  parameter int unsigned WIDTH = 6
) (
  input  logic [WIDTH-1:0] value_i,
  input  step_dir_e        dir_i,
  input  logic [WIDTH-1:0] min_i,
  input  logic [WIDTH-1:0] eff_max_i,
  output logic [WIDTH-1:0] next_value_c,
  output logic             wrap_c
);

  localparam int unsigned XW = WIDTH + 1;

  logic [XW-1:0] val_x;
  logic [XW-1:0] inc_x;
  logic [XW-1:0] dec_x;

  assign val_x = XW'(value_i);
  assign inc_x = val_x + XW'(1);
  assign dec_x = val_x - XW'(1);

  // Non-wrapping paths never leave [min, eff_max], so truncation is lossless.
  always_comb begin
    next_value_c = value_i;
    wrap_c       = 1'b0;
    if (dir_i == DIR_UP) begin
      if (value_i == eff_max_i) begin
        next_value_c = min_i;
        wrap_c       = 1'b1;
      end else begin
        next_value_c = WIDTH'(inc_x);
      end
    end else begin
      if (value_i == min_i) begin
        next_value_c = eff_max_i;
        wrap_c       = 1'b1;
      end else begin
        next_value_c = WIDTH'(dec_x);
      end
    end
  end

endmodule

// File: rtl/time_unit_counter.sv
// One chained clock unit: modulo counter with run/setup stepping, parallel load,
// runtime upper bound and registered one-cycle carry/borrow pulses.
module time_unit_counter
  import clock_pkg::*;
#(
  parameter int unsigned WIDTH           = 6,
  parameter int unsigned MIN_VAL         = 0,
  parameter int unsigned MAX_VAL         = 59,
  parameter bit          DYN_LIMIT       = 1'b0,
  parameter bit          SETUP_PROPAGATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             carry_in,
  input  logic             setup_sel,
  input  logic             setup_tick,
  input  logic             setup_up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] limit_max,
  output logic [WIDTH-1:0] value,
  output logic             carry_out,
  output logic             borrow_out
);

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] value_q, value_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;

  logic [WIDTH-1:0] eff_max;
  logic [WIDTH-1:0] load_sat;
  logic [WIDTH-1:0] step_next;
  logic             step_wrap;
  logic             step_en;
  step_dir_e        step_dir;
  logic             below_min_val;
  logic             below_min_load;
  logic             below_min_lim;

  // Lower-bound compares only exist when the range does not start at zero.
  generate
    if (MIN_VAL == 0) begin : g_min_zero
      assign below_min_val  = 1'b0;
      assign below_min_load = 1'b0;
      assign below_min_lim  = 1'b0;
    end else begin : g_min_pos
      assign below_min_val  = value_q < MIN_V;
      assign below_min_load = load_value < MIN_V;
      assign below_min_lim  = limit_max < MIN_V;
    end
  endgenerate

  always_comb begin
    eff_max = MAX_V;
    if (DYN_LIMIT) begin
      if (below_min_lim)          eff_max = MIN_V;
      else if (limit_max > MAX_V) eff_max = MAX_V;
      else                        eff_max = limit_max;
    end
  end

  always_comb begin
    load_sat = load_value;
    if (below_min_load)            load_sat = MIN_V;
    else if (load_value > eff_max) load_sat = eff_max;
  end

  assign step_dir = (run || setup_up) ? DIR_UP : DIR_DOWN;
  assign step_en  = run ? carry_in : (setup_tick && setup_sel);

  unit_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .value_i      (value_q),
    .dir_i        (step_dir),
    .min_i        (MIN_V),
    .eff_max_i    (eff_max),
    .next_value_c (step_next),
    .wrap_c       (step_wrap)
  );

  // Priority: load, then out-of-range clamp, then the mode's step.
  always_comb begin
    value_d  = value_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (load) begin
      value_d = load_sat;
    end else if (value_q > eff_max) begin
      value_d = eff_max;
    end else if (below_min_val) begin
      value_d = MIN_V;
    end else if (step_en) begin
      value_d = step_next;
      if (run) begin
        carry_d = step_wrap;
      end else if (SETUP_PROPAGATE) begin
        carry_d  = step_wrap && (step_dir == DIR_UP);
        borrow_d = step_wrap && (step_dir == DIR_DOWN);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q  <= MIN_V;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      value_q  <= value_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign value      = value_q;
  assign carry_out  = carry_q;
  assign borrow_out = borrow_q;

endmodule
